sdf_stage_ctrl: RTL and testbench
=================================

SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 SHALL have parameter LENGTH, default 16, the feedback delay-line depth D; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter TW_W, default 4, the twiddle index width; it SHALL equal log2(LENGTH).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, which marks a sample presented this cycle.
REQ-006 SHALL have port in_first, input, 1 bit, which marks the first sample of a 2D-sample frame and is qualified by in_valid.
REQ-007 SHALL have port in_last, input, 1 bit, which marks the last sample of the final frame of a stream and is qualified by in_valid.
REQ-008 SHALL have port sr_en, output, 1 bit, the shift enable for the delay line.
REQ-009 SHALL have port bf_sel, output, 1 bit: 0 = load/bypass (input into delay line, delay-line output to stage output); 1 = butterfly (sum out, difference into delay line).
REQ-010 SHALL have port tw_idx, output, TW_W bits, the twiddle ROM index for the current stage output.
REQ-011 SHALL have port out_valid, output, 1 bit, which marks a valid stage output this cycle.
REQ-012 SHALL have port out_first, output, 1 bit, which marks the first output of a frame.
REQ-013 SHALL have port out_last, output, 1 bit, which marks the final output of a stream.
REQ-014 SHALL have port busy, output, 1 bit, which is high in any state other than IDLE.
REQ-015 SHALL have port err_sync, output, 1 bit, a sticky framing-error flag.

Function
REQ-016 SHALL implement states IDLE, FILL, RUN and DRAIN plus a counter cnt of width TW_W+1 that counts modulo 2D.
REQ-017 "accept" SHALL mean in_valid=1 in FILL or RUN, or in IDLE with in_first=1; each accept advances cnt by 1 and wraps from 2D-1 to 0.
REQ-018 In IDLE, an accept with in_first=1 SHALL set cnt to 1 and move to FILL; in IDLE, in_valid without in_first SHALL be ignored.
REQ-019 In FILL: bf_sel=0 and out_valid=0; the accept with cnt=D-1 SHALL move to RUN.
REQ-020 In RUN: bf_sel=1 when cnt>=D, otherwise 0; out_valid SHALL equal accept.
REQ-021 In RUN, an accept with in_last=1 SHALL move to DRAIN with cnt=0; in_last SHALL be legal only when cnt=2D-1.
REQ-022 In DRAIN: sr_en=1, bf_sel=0, out_valid=1 every cycle; cnt advances each cycle; out_last=1 when cnt=D-1; the following edge SHALL go to IDLE with cnt=0.
REQ-023 tw_idx SHALL equal cnt[TW_W-1:0] when bf_sel=0 and out_valid=1, and SHALL be 0 otherwise.
REQ-024 out_first SHALL be 1 on the RUN accept with cnt=D, and 0 otherwise.
REQ-025 A framing error SHALL occur on in_first with cnt!=0 in FILL/RUN, or on in_last with cnt!=2D-1; it SHALL set err_sync and resync the block: cnt set to 1, state set to FILL, and the offending sample treated as frame sample 0.
REQ-026 Simultaneous in_first and in_last on one accept SHALL be treated as a framing error.
REQ-027 All outputs except err_sync SHALL be combinational decodes of registered state, registered cnt and in_valid, with zero added latency; err_sync SHALL be registered.

Reset
REQ-028 rst=0 SHALL asynchronously force state=IDLE, cnt=0 and err_sync=0, regardless of the current state, including mid-FILL, mid-RUN or mid-DRAIN.
REQ-029 While rst=0, outputs SHALL be sr_en=0, bf_sel=0, tw_idx=0, out_valid=0, out_first=0, out_last=0, busy=0 and err_sync=0.
REQ-030 Reset release SHALL take effect at the first rising edge of clk with rst=1; no partial frame or drain SHALL resume.

Configuration
REQ-031 Macro SDF_CTRL_STALL_EN defined: sr_en SHALL equal accept in FILL/RUN; cnt and state SHALL hold while in_valid=0 (input gaps allowed mid-frame).
REQ-032 Macro SDF_CTRL_STALL_EN undefined: in FILL/RUN, sr_en=1 and cnt advances every cycle regardless of in_valid; out_valid in RUN SHALL be 1 every cycle; in_first/in_last SHALL still be sampled only with in_valid=1.

Verification
REQ-033 LENGTH=16: in_first at t0, then 32 continuous samples with in_last on the 32nd -> FILL for 16 cycles, out_first at sample 16, bf_sel=1 for samples 16..31, DRAIN for 16 cycles with tw_idx 0..15, out_last on drain cycle 15, then busy=0.
REQ-034 Two back-to-back frames, in_first at samples 0 and 32 -> no DRAIN between frames, err_sync=0, and out_valid continuous from sample 16 through the end of the drain.
REQ-035 in_first at cnt=5 in RUN -> err_sync=1 from the next edge, cnt=1, state=FILL; err_sync stays 1 until rst.
REQ-036 rst pulsed low during DRAIN at cnt=7 -> all outputs 0 immediately; after release with in_valid=0, the block stays in IDLE.
REQ-037 With SDF_CTRL_STALL_EN: 3-cycle in_valid=0 gap at cnt=20 -> sr_en=0, out_valid=0, cnt holds at 20, and bf_sel stays 1 during the gap.
REQ-038 LENGTH=2, TW_W=1: 4-sample frame with in_last -> FILL 2 cycles, RUN 2, DRAIN 2, out_last on drain cycle 1.

Source files
------------

// File: rtl/sdf_stage_ctrl.sv
// Single-path delay-feedback (SDF) FFT stage controller.
// Sequences the feedback delay line (depth LENGTH) and the butterfly mux,
// supplies the twiddle ROM index and frames the stage output stream.
// TW_W must equal log2(LENGTH); LENGTH is a power of two from 2 to 16.
//
// Optional build macro SDF_CTRL_STALL_EN: when defined, FILL/RUN hold
// (counter and state) whenever in_valid is low, allowing input gaps
// mid-frame. When undefined, FILL/RUN advance every clock.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for in_first; sample 0 of a frame is loaded here
// FILL  | loading the first half of a frame into the delay line
// RUN   | butterflies in the second half, first half of the next frame
// DRAIN | flushing the last frame's differences out of the delay line

module sdf_stage_ctrl #(
    parameter int LENGTH = 16,
    parameter int TW_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_first,
    input  logic            in_last,
    output logic            sr_en,
    output logic            bf_sel,
    output logic [TW_W-1:0] tw_idx,
    output logic            out_valid,
    output logic            out_first,
    output logic            out_last,
    output logic            busy,
    output logic            err_sync
);

    localparam int CW = TW_W + 1;
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DM1  = CW'(LENGTH - 1);
    localparam logic [CW-1:0] CNT_D    = CW'(LENGTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            err_nxt;
    logic            accept;
    logic            adv;
    logic            frame_err;

    // A sample is taken in FILL/RUN on any valid, in IDLE only when it opens a frame.
    assign accept = in_valid && ((state == FILL) || (state == RUN) ||
                                 ((state == IDLE) && in_first));

    // Whether FILL/RUN move forward this cycle.
`ifdef SDF_CTRL_STALL_EN
    assign adv = in_valid;
`else
    assign adv = 1'b1;
`endif

    // Frame markers disagreeing with the counter position force a resync.
    assign frame_err = accept && ((in_first && in_last) ||
                                  (in_first && (cnt != CNT_ZERO)) ||
                                  (in_last && (cnt != CNT_LAST)));

    // State, counter and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= CNT_ZERO;
            err_sync <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            err_sync <= err_nxt;
        end
    end

    // Next-state and counter update; a framing error restarts at frame sample 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_sync;
        if (frame_err) begin
            state_nxt = FILL;
            cnt_nxt   = CNT_ONE;
            err_nxt   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_nxt = FILL;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                FILL: begin
                    if (adv) begin
                        cnt_nxt = cnt + CNT_ONE;
                        if (cnt == CNT_DM1) begin
                            state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    if (adv) begin
                        if (accept && in_last) begin
                            state_nxt = DRAIN;
                            cnt_nxt   = CNT_ZERO;
                        end else begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == CNT_DM1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = CNT_ZERO;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // Datapath controls decoded from the registered state and counter.
    always_comb begin
        sr_en     = 1'b0;
        bf_sel    = 1'b0;
        out_valid = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                // Sample 0 must enter the delay line on the opening accept;
                // gated by rst so nothing shifts while reset is held.
                sr_en = rst && accept;
            end
            FILL: begin
                sr_en = adv;
            end
            RUN: begin
                sr_en     = adv;
                out_valid = adv;
                bf_sel    = (cnt >= CNT_D);
                out_first = adv && (cnt == CNT_D);
            end
            DRAIN: begin
                sr_en     = 1'b1;
                out_valid = 1'b1;
                out_last  = (cnt == CNT_DM1);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        tw_idx = (out_valid && !bf_sel) ? cnt[TW_W-1:0] : '0;
    end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Self-checking bench for sdf_stage_ctrl: a LENGTH=16 and a LENGTH=2
// instance share one input stream; each is compared every cycle against
// a frame-position model. Honours SDF_CTRL_STALL_EN like the design.

module tb_sdf_stage_ctrl;

    localparam int L_A  = 16;
    localparam int TW_A = 4;
    localparam int L_B  = 2;
    localparam int TW_B = 1;

`ifdef SDF_CTRL_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    localparam int PH_IDLE  = 0;
    localparam int PH_FILL  = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_DRAIN = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic in_first = 1'b0;
    logic in_last  = 1'b0;

    logic            sr_en_a, bf_sel_a, ov_a, of_a, ol_a, busy_a, err_a;
    logic [TW_A-1:0] tw_a;
    logic            sr_en_b, bf_sel_b, ov_b, of_b, ol_b, busy_b, err_b;
    logic [TW_B-1:0] tw_b;

    always #5 clk = ~clk;

    sdf_stage_ctrl #(.LENGTH(L_A), .TW_W(TW_A)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .sr_en(sr_en_a), .bf_sel(bf_sel_a), .tw_idx(tw_a),
        .out_valid(ov_a), .out_first(of_a), .out_last(ol_a), .busy(busy_a),
        .err_sync(err_a)
    );

    sdf_stage_ctrl #(.LENGTH(L_B), .TW_W(TW_B)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .sr_en(sr_en_b), .bf_sel(bf_sel_b), .tw_idx(tw_b),
        .out_valid(ov_b), .out_first(of_b), .out_last(ol_b), .busy(busy_b),
        .err_sync(err_b)
    );

    // Model: phase of the stream plus position of the current sample in its 2D frame.
    typedef struct {
        int ph;
        int pos;
        bit err;
    } mdl_t;

    typedef struct {
        int sr;
        int bf;
        int tw;
        int ov;
        int of;
        int ol;
        int busy;
        int err;
    } exp_t;

    mdl_t ma, mb;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.ph  = PH_IDLE;
        m.pos = 0;
        m.err = 1'b0;
        return m;
    endfunction

    function automatic exp_t expect_out(mdl_t m, int d, bit v, bit f, bit r);
        exp_t e = '{default: 0};
        int   go;
        go = STALL ? int'(v) : 1;
        if (!r) return e;
        e.busy = (m.ph != PH_IDLE);
        e.err  = m.err;
        case (m.ph)
            PH_IDLE:  e.sr = v && f;
            PH_FILL:  e.sr = go;
            PH_RUN: begin
                e.sr = go;
                e.ov = go;
                e.bf = (m.pos >= d);
                e.of = (go != 0) && (m.pos == d);
            end
            default: begin
                e.sr = 1;
                e.ov = 1;
                e.ol = (m.pos == d - 1);
            end
        endcase
        if (e.ov != 0 && e.bf == 0) e.tw = m.pos % d;
        return e;
    endfunction

    function automatic mdl_t model_next(mdl_t m, int d, bit v, bit f, bit l);
        mdl_t n = m;
        bit   acc, go, bad;
        acc = v && (m.ph == PH_FILL || m.ph == PH_RUN || (m.ph == PH_IDLE && f));
        go  = STALL ? v : 1'b1;
        bad = acc && ((f && l) || (f && m.pos != 0) || (l && m.pos != 2*d - 1));
        if (bad) begin
            n.ph  = PH_FILL;
            n.pos = 1;
            n.err = 1'b1;
            return n;
        end
        case (m.ph)
            PH_IDLE: if (acc) begin
                n.ph  = PH_FILL;
                n.pos = 1;
            end
            PH_FILL: if (go) begin
                n.pos = m.pos + 1;
                if (n.pos == d) n.ph = PH_RUN;
            end
            PH_RUN: if (go) begin
                if (acc && l) begin
                    n.ph  = PH_DRAIN;
                    n.pos = 0;
                end else begin
                    n.pos = (m.pos + 1) % (2*d);
                end
            end
            default: begin
                if (m.pos == d - 1) begin
                    n.ph  = PH_IDLE;
                    n.pos = 0;
                end else begin
                    n.pos = m.pos + 1;
                end
            end
        endcase
        return n;
    endfunction

    task automatic compare_all();
        exp_t ea, eb;
        ea = expect_out(ma, L_A, in_valid, in_first, rst);
        eb = expect_out(mb, L_B, in_valid, in_first, rst);
        check_eq("a.sr_en",     int'(sr_en_a),  ea.sr);
        check_eq("a.bf_sel",    int'(bf_sel_a), ea.bf);
        check_eq("a.tw_idx",    int'(tw_a),     ea.tw);
        check_eq("a.out_valid", int'(ov_a),     ea.ov);
        check_eq("a.out_first", int'(of_a),     ea.of);
        check_eq("a.out_last",  int'(ol_a),     ea.ol);
        check_eq("a.busy",      int'(busy_a),   ea.busy);
        check_eq("a.err_sync",  int'(err_a),    ea.err);
        check_eq("b.sr_en",     int'(sr_en_b),  eb.sr);
        check_eq("b.bf_sel",    int'(bf_sel_b), eb.bf);
        check_eq("b.tw_idx",    int'(tw_b),     eb.tw);
        check_eq("b.out_valid", int'(ov_b),     eb.ov);
        check_eq("b.out_first", int'(of_b),     eb.of);
        check_eq("b.out_last",  int'(ol_b),     eb.ol);
        check_eq("b.busy",      int'(busy_b),   eb.busy);
        check_eq("b.err_sync",  int'(err_b),    eb.err);
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, advance models on the edge.
    task automatic cycle(input bit v, input bit f, input bit l);
        mdl_t na, nb;
        @(negedge clk);
        in_valid = v;
        in_first = f;
        in_last  = l;
        #1;
        compare_all();
        na = model_next(ma, L_A, v, f, l);
        nb = model_next(mb, L_B, v, f, l);
        @(posedge clk);
        ma = na;
        mb = nb;
    endtask

    // Pull reset low mid-cycle with a frame-opening input present, then release idle.
    task automatic reset_mid();
        @(negedge clk);
        in_valid = 1'b1;
        in_first = 1'b1;
        in_last  = 1'b0;
        #2;
        rst = 1'b0;
        ma  = mdl_reset();
        mb  = mdl_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        @(posedge clk);
    endtask

    // Continuous frames of 2*L_A samples; optional stray in_first at sample err_at.
    task automatic run_frames(input int nfr, input int err_at);
        for (int i = 0; i < 2*L_A*nfr; i++) begin
            cycle(1'b1, (i % (2*L_A) == 0) || (i == err_at), i == 2*L_A*nfr - 1);
        end
    endtask

    initial begin
        ma = mdl_reset();
        mb = mdl_reset();
        in_valid = 1'b1;
        in_first = 1'b1;
        #3;
        compare_all();
        in_valid = 1'b0;
        in_first = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Stray markers in IDLE are ignored.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);

        // Single frame, then back-to-back frames.
        run_frames(1, -1);
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        check_eq("a.idle_after_frame", int'(busy_a), 0);
        check_eq("a.no_err_frame", int'(err_a), 0);
        run_frames(2, -1);
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        check_eq("a.no_err_b2b", int'(err_a), 0);

        // Stray in_first at RUN position 5 (sample 37) resyncs and sticks.
        run_frames(2, 2*L_A + 5);
        repeat (40) cycle(1'b0, 1'b0, 1'b0);
        check_eq("a.err_sticky", int'(err_a), 1);

        // Reset in DRAIN at position 7, then stay idle.
        reset_mid();
        run_frames(1, -1);
        repeat (7) cycle(1'b0, 1'b0, 1'b0);
        reset_mid();
        repeat (6) cycle(1'b0, 1'b0, 1'b0);
        check_eq("a.idle_after_rst", int'(busy_a), 0);

        // Simultaneous first/last in IDLE is a framing error.
        cycle(1'b1, 1'b1, 1'b1);
        repeat (40) cycle(1'b0, 1'b0, 1'b0);
        reset_mid();

        // Randomised stream biased toward well-formed frames, with gaps and resets.
        for (int k = 0; k < 3000; k++) begin
            bit v, f, l;
            v = ($urandom_range(0, 7) != 0);
            f = (ma.pos == 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 63) == 0);
            l = (ma.ph == PH_RUN && ma.pos == 2*L_A - 1 && $urandom_range(0, 2) == 0) ||
                ($urandom_range(0, 127) == 0);
            if ($urandom_range(0, 599) == 0) begin
                reset_mid();
            end else begin
                cycle(v, f, l);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
